// File: rtl/ram_ctrl_pkg.sv
// ram_ctrl_pkg: shared state type, client ids, default sizes and one-hot decode for the RAM access arbiter
package ram_ctrl_pkg;
  typedef enum logic {INIT, RUN} state_t;
  localparam logic CLI_A = 1'b0;
  localparam logic CLI_B = 1'b1;
  localparam int DW_DEF = 2;
  localparam int AW_DEF = 2;
  localparam int MAX_WORDS = 256;
  function automatic logic [MAX_WORDS-1:0] onehot(input logic [7:0] idx);
    return {{(MAX_WORDS-1){1'b0}}, 1'b1} << idx;
  endfunction
endpackage

// File: rtl/rr_arbiter2.sv
// rr_arbiter2: two-way round-robin grant for the shared RAM write port
//   clk, reset (async, active low), req_a/req_b write requests -> gnt_a/gnt_b
//   prio names the client that wins the next contended cycle; it moves to the loser after every grant
module rr_arbiter2
  import ram_ctrl_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic req_a,
  input  logic req_b,
  output logic gnt_a,
  output logic gnt_b
);
  logic prio;
  always_comb begin
    gnt_a = req_a & (~req_b | (prio == CLI_A));
    gnt_b = req_b & (~req_a | (prio == CLI_B));
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) prio <= CLI_A;
    else if (gnt_a | gnt_b) prio <= gnt_a ? CLI_B : CLI_A;
endmodule

// File: rtl/ram_access_arbiter.sv
// ram_access_arbiter: clears a WORDS x DW register-file RAM after reset, then shares it between clients A and B
//   clk, reset (async, active low)
//   a_*/b_*: req, we, addr, wdata in; gnt (combinational), rvalid/rdata (registered, 1-cycle latency) out
//   ram_write_data/ram_write_select: shared write port (one-hot or zero select)
//   ram_read_select_1/2 + ram_read_data_1/2: dedicated read ports for A and B
//   init_done: high once every word has been cleared
//   RAM_WRITE_BYPASS_EN: a read granted with a same-address write returns the new data
module ram_access_arbiter
  import ram_ctrl_pkg::*;
#(
  parameter  int DW = DW_DEF,
  parameter  int AW = AW_DEF,
  localparam int WORDS = 2**AW
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             a_req,
  input  logic             a_we,
  input  logic [AW-1:0]    a_addr,
  input  logic [DW-1:0]    a_wdata,
  output logic             a_gnt,
  output logic             a_rvalid,
  output logic [DW-1:0]    a_rdata,
  input  logic             b_req,
  input  logic             b_we,
  input  logic [AW-1:0]    b_addr,
  input  logic [DW-1:0]    b_wdata,
  output logic             b_gnt,
  output logic             b_rvalid,
  output logic [DW-1:0]    b_rdata,
  output logic [DW-1:0]    ram_write_data,
  output logic [WORDS-1:0] ram_write_select,
  output logic [WORDS-1:0] ram_read_select_1,
  output logic [WORDS-1:0] ram_read_select_2,
  input  logic [DW-1:0]    ram_read_data_1,
  input  logic [DW-1:0]    ram_read_data_2,
  output logic             init_done
);
  state_t state, state_nx;
  logic [AW-1:0] init_cnt;
  logic run, a_rd, b_rd, a_wg, b_wg, wen;
  logic [AW-1:0] waddr;
  logic [DW-1:0] wdata, a_rdata_nx, b_rdata_nx;
  rr_arbiter2 u_arb (
    .clk   (clk),
    .reset (reset),
    .req_a (run & a_req & a_we),
    .req_b (run & b_req & b_we),
    .gnt_a (a_wg),
    .gnt_b (b_wg)
  );
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state    <= INIT;
      init_cnt <= '0;
    end else begin
      state <= state_nx;
      if (state == INIT) init_cnt <= init_cnt + AW'(1);
    end
  // the INIT select is gated by reset so nothing is written while reset is held
  always_comb begin
    state_nx          = (state == INIT && &init_cnt) ? RUN : state;
    run               = state == RUN;
    a_rd              = run & a_req & ~a_we;
    b_rd              = run & b_req & ~b_we;
    a_gnt             = a_rd | a_wg;
    b_gnt             = b_rd | b_wg;
    wen               = a_wg | b_wg;
    waddr             = a_wg ? a_addr : b_addr;
    wdata             = a_wg ? a_wdata : b_wdata;
    ram_write_select  = run ? (wen ? WORDS'(onehot(8'(waddr))) : '0)
                            : (reset ? WORDS'(onehot(8'(init_cnt))) : '0);
    ram_write_data    = (run & wen) ? wdata : '0;
    ram_read_select_1 = a_rd ? WORDS'(onehot(8'(a_addr))) : '0;
    ram_read_select_2 = b_rd ? WORDS'(onehot(8'(b_addr))) : '0;
    init_done         = run;
  end
`ifdef RAM_WRITE_BYPASS_EN
  assign a_rdata_nx = (wen && waddr == a_addr) ? wdata : ram_read_data_1;
  assign b_rdata_nx = (wen && waddr == b_addr) ? wdata : ram_read_data_2;
`else
  assign a_rdata_nx = ram_read_data_1;
  assign b_rdata_nx = ram_read_data_2;
`endif
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      a_rvalid <= 1'b0;
      b_rvalid <= 1'b0;
      a_rdata  <= '0;
      b_rdata  <= '0;
    end else begin
      a_rvalid <= a_rd;
      b_rvalid <= b_rd;
      if (a_rd) a_rdata <= a_rdata_nx;
      if (b_rd) b_rdata <= b_rdata_nx;
    end
endmodule

// File: tb/tb_ram_access_arbiter.sv
// tb_ram_access_arbiter: directed test of ram_access_arbiter against a transaction-level model with an attached RAM
module tb_ram_access_arbiter;
  localparam int WORDS = 4;
`ifdef RAM_WRITE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif
  logic clk = 1'b0, reset = 1'b0;
  logic a_req = 1'b0, a_we = 1'b0, b_req = 1'b0, b_we = 1'b0;
  logic [1:0] a_addr = '0, b_addr = '0, a_wdata = '0, b_wdata = '0;
  logic a_gnt, b_gnt, a_rvalid, b_rvalid, init_done;
  logic [1:0] a_rdata, b_rdata, ram_write_data, rd1, rd2;
  logic [3:0] ram_write_select, rs1, rs2;
  int checks = 0, errors = 0;
  logic [1:0] mem   [WORDS] = '{2'b11, 2'b10, 2'b01, 2'b11};
  logic [1:0] m_mem [WORDS] = '{2'b11, 2'b10, 2'b01, 2'b11};
  int m_cnt = 0;
  bit m_next_b = 1'b0;
  logic m_arv = 1'b0, m_brv = 1'b0;
  logic [1:0] m_ard = '0, m_brd = '0;
  logic e_init, e_ard, e_brd, e_aw, e_bw, e_agnt, e_bgnt;
  int e_win;
  logic [1:0] e_waddr, e_wdata;
  logic [3:0] e_wsel, e_rs1, e_rs2;
  logic [3:0] ga, gb;

  ram_access_arbiter dut (
    .clk(clk), .reset(reset),
    .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
    .a_gnt(a_gnt), .a_rvalid(a_rvalid), .a_rdata(a_rdata),
    .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
    .b_gnt(b_gnt), .b_rvalid(b_rvalid), .b_rdata(b_rdata),
    .ram_write_data(ram_write_data), .ram_write_select(ram_write_select),
    .ram_read_select_1(rs1), .ram_read_select_2(rs2),
    .ram_read_data_1(rd1), .ram_read_data_2(rd2),
    .init_done(init_done)
  );

  always #5 clk = ~clk;

  always @(posedge clk)
    for (int i = 0; i < WORDS; i++) if (ram_write_select[i]) mem[i] <= ram_write_data;
  always_comb begin
    rd1 = '0;
    rd2 = '0;
    for (int i = 0; i < WORDS; i++) begin
      if (rs1[i]) rd1 = rd1 | mem[i];
      if (rs2[i]) rd2 = rd2 | mem[i];
    end
  end

  always_comb begin
    e_init  = m_cnt < WORDS;
    e_ard   = !e_init && a_req && !a_we;
    e_brd   = !e_init && b_req && !b_we;
    e_aw    = !e_init && a_req && a_we;
    e_bw    = !e_init && b_req && b_we;
    e_win   = (e_aw && e_bw) ? (m_next_b ? 2 : 1) : e_aw ? 1 : e_bw ? 2 : 0;
    e_agnt  = e_ard || e_win == 1;
    e_bgnt  = e_brd || e_win == 2;
    e_waddr = (e_win == 1) ? a_addr : b_addr;
    e_wdata = e_init ? 2'b00 : (e_win == 1) ? a_wdata : (e_win == 2) ? b_wdata : 2'b00;
    e_wsel  = e_init ? 4'(1 << m_cnt) : (e_win != 0) ? 4'(1 << e_waddr) : 4'b0000;
    e_rs1   = e_ard ? 4'(1 << a_addr) : 4'b0000;
    e_rs2   = e_brd ? 4'(1 << b_addr) : 4'b0000;
  end

  always @(posedge clk or negedge reset)
    if (!reset) begin
      m_cnt    <= 0;
      m_next_b <= 1'b0;
      m_arv    <= 1'b0;
      m_brv    <= 1'b0;
      m_ard    <= '0;
      m_brd    <= '0;
    end else begin
      m_arv <= e_ard;
      m_brv <= e_brd;
      if (e_ard) m_ard <= (BYP && e_win != 0 && e_waddr == a_addr) ? e_wdata : m_mem[a_addr];
      if (e_brd) m_brd <= (BYP && e_win != 0 && e_waddr == b_addr) ? e_wdata : m_mem[b_addr];
      if (e_init) m_mem[2'(m_cnt)] <= 2'b00;
      else if (e_win != 0) m_mem[e_waddr] <= e_wdata;
      if (e_win == 1) m_next_b <= 1'b1;
      else if (e_win == 2) m_next_b <= 1'b0;
      if (e_init) m_cnt <= m_cnt + 1;
    end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s act=%0h want=%0h t=%0t", nm, act, want, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial forever begin
    @(negedge clk);
    if (reset) begin
      chk("m_a_gnt", 32'(a_gnt), 32'(e_agnt));
      chk("m_b_gnt", 32'(b_gnt), 32'(e_bgnt));
      chk("m_wsel", 32'(ram_write_select), 32'(e_wsel));
      chk("m_wdata", 32'(ram_write_data), 32'(e_wdata));
      chk("m_rs1", 32'(rs1), 32'(e_rs1));
      chk("m_rs2", 32'(rs2), 32'(e_rs2));
      chk("m_done", 32'(init_done), 32'(!e_init));
      chk("m_a_rvalid", 32'(a_rvalid), 32'(m_arv));
      chk("m_b_rvalid", 32'(b_rvalid), 32'(m_brv));
      chk("m_a_rdata", 32'(a_rdata), 32'(m_ard));
      chk("m_b_rdata", 32'(b_rdata), 32'(m_brd));
      for (int i = 0; i < WORDS; i++) chk("m_mem", 32'(mem[i]), 32'(m_mem[i]));
    end
  end

  initial begin
    a_req = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_a_gnt", 32'(a_gnt), 0);
    chk("rst_done", 32'(init_done), 0);
    chk("rst_wsel", 32'(ram_write_select), 0);
    chk("rst_a_rvalid", 32'(a_rvalid), 0);
    chk("rst_a_rdata", 32'(a_rdata), 0);
    reset = 1'b1;
    for (int k = 0; k < WORDS; k++) begin
      @(negedge clk);
      chk("init_wsel", 32'(ram_write_select), 32'(1 << k));
      chk("init_wdata", 32'(ram_write_data), 0);
      chk("init_a_gnt", 32'(a_gnt), 0);
      chk("init_done_lo", 32'(init_done), 0);
      step();
    end
    a_we = 1'b1; a_addr = 2'd1; a_wdata = 2'b10;
    @(negedge clk);
    chk("init_done_hi", 32'(init_done), 1);
    chk("wr_a_gnt", 32'(a_gnt), 1);
    chk("wr_wsel", 32'(ram_write_select), 2);
    chk("wr_wdata", 32'(ram_write_data), 2);
    step();
    a_we = 1'b0;
    @(negedge clk);
    chk("rd_a_gnt", 32'(a_gnt), 1);
    chk("rd_rs1", 32'(rs1), 2);
    step();
    a_req = 1'b0;
    chk("rd_a_rvalid", 32'(a_rvalid), 1);
    chk("rd_a_rdata", 32'(a_rdata), 2);
    a_req = 1'b1; a_we = 1'b0; a_addr = 2'd0;
    b_req = 1'b1; b_we = 1'b1; b_addr = 2'd0; b_wdata = 2'b11;
    @(negedge clk);
    chk("byp_a_gnt", 32'(a_gnt), 1);
    chk("byp_b_gnt", 32'(b_gnt), 1);
    step();
    a_req = 1'b0; b_req = 1'b0;
    chk("byp_a_rvalid", 32'(a_rvalid), 1);
    chk("byp_a_rdata", 32'(a_rdata), BYP ? 3 : 0);
    a_req = 1'b1; a_we = 1'b1; a_addr = 2'd2; a_wdata = 2'b01;
    b_req = 1'b1; b_we = 1'b1; b_addr = 2'd3; b_wdata = 2'b11;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      ga[3-k] = a_gnt;
      gb[3-k] = b_gnt;
      step();
    end
    a_req = 1'b0; b_req = 1'b0;
    chk("rr_a_seq", 32'(ga), 'b1010);
    chk("rr_b_seq", 32'(gb), 'b0101);
    chk("rr_word2", 32'(mem[2]), 1);
    chk("rr_word3", 32'(mem[3]), 3);
    b_req = 1'b1; b_we = 1'b1; b_addr = 2'd3; b_wdata = 2'b01;
    step();
    a_req = 1'b1; a_we = 1'b0; a_addr = 2'd3;
    b_we = 1'b0;
    @(negedge clk);
    chk("same_a_gnt", 32'(a_gnt), 1);
    chk("same_b_gnt", 32'(b_gnt), 1);
    step();
    a_req = 1'b0; b_req = 1'b0;
    chk("same_a_rvalid", 32'(a_rvalid), 1);
    chk("same_b_rvalid", 32'(b_rvalid), 1);
    chk("same_a_rdata", 32'(a_rdata), 1);
    chk("same_b_rdata", 32'(b_rdata), 1);
    a_req = 1'b1; a_we = 1'b0; a_addr = 2'd1;
    #3 reset = 1'b0;
    step();
    chk("mid_a_rvalid", 32'(a_rvalid), 0);
    chk("mid_a_gnt", 32'(a_gnt), 0);
    chk("mid_done", 32'(init_done), 0);
    a_req = 1'b0;
    step();
    reset = 1'b1;
    repeat (WORDS) step();
    chk("reinit_done", 32'(init_done), 1);
    for (int i = 0; i < WORDS; i++) chk("reinit_word", 32'(mem[i]), 0);
    a_req = 1'b1; a_we = 1'b0; a_addr = 2'd1;
    step();
    a_req = 1'b0;
    chk("reinit_a_rvalid", 32'(a_rvalid), 1);
    chk("reinit_a_rdata", 32'(a_rdata), 0);
    repeat (2) step();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
